// File: rtl/yuv422_capture_ctrl_pkg.sv
// yuv422_capture_ctrl_pkg: shared state encoding, widths and pixel-pair packing helpers
package yuv422_capture_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_VS, CAPTURE, FLUSH, DONE} cap_state_t;
  localparam int DEF_FIFO_AW = 4;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_CW = 11;
  localparam int PIX_W = 16;
  localparam logic [PIX_W-1:0] PIX_PAD = '0;
  function automatic logic [31:0] pack_pair(input logic [PIX_W-1:0] hi, input logic [PIX_W-1:0] lo);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/yuv_word_fifo.sv
// yuv_word_fifo: show-ahead synchronous 32-bit FIFO; writes into a full FIFO are dropped
module yuv_word_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);
  logic [31:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] cnt;
  logic we, re;
  assign full = cnt[FIFO_AW];
  assign empty = cnt == '0;
  assign we = wr_en & ~full;
  assign re = rd_en & ~empty;
  assign rd_data = mem[rp];
  always_ff @(posedge sys_clk)
    if (we) mem[wp] <= wr_data;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (we) wp <= wp + FIFO_AW'(1);
      if (re) rp <= rp + FIFO_AW'(1);
      cnt <= cnt + (FIFO_AW+1)'(we) - (FIFO_AW+1)'(re);
    end
endmodule

// File: rtl/yuv422_capture_ctrl.sv
// yuv422_capture_ctrl: crops a window from the YUV422 stream, packs pixel pairs
// into 32-bit words and writes them to memory for a programmed number of frames
module yuv422_capture_ctrl
  import yuv422_capture_ctrl_pkg::*;
#(
  parameter int FIFO_AW = DEF_FIFO_AW,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CW = DEF_CW
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [15:0]       yuv_d,
  input  logic              yuv_de,
  input  logic              yuv_hsync,
  input  logic              yuv_vsync,
  input  logic              cap_start,
  input  logic              cap_stop,
  input  logic [CW-1:0]     cfg_x0,
  input  logic [CW-1:0]     cfg_y0,
  input  logic [CW-1:0]     cfg_w,
  input  logic [CW-1:0]     cfg_h,
  input  logic [7:0]        cfg_frames,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              err_ovf,
  output logic              err_short
);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW:0] ONE = (CW+1)'(1);
  cap_state_t state;
  logic vs_q, hs_q, line_de, stop_pend, phase, push_v;
  logic [CW-1:0] pix_cnt, line_cnt, win_x0, win_y0, win_w, win_h;
  logic [7:0] frames_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0] lo;
  logic [31:0] push_w, head;
  logic [CW:0] x_end, y_end;
  logic vs_rise, hs_fall, in_x, in_y, last_x, last_y, pix, eof, fifo_full, fifo_empty, pop;
  assign vs_rise = yuv_vsync & ~vs_q;
  assign hs_fall = hs_q & ~yuv_hsync;
  assign x_end = {1'b0, win_x0} + {1'b0, win_w};
  assign y_end = {1'b0, win_y0} + {1'b0, win_h};
  assign in_x = {1'b0, pix_cnt} >= {1'b0, win_x0} && {1'b0, pix_cnt} < x_end;
  assign in_y = {1'b0, line_cnt} >= {1'b0, win_y0} && {1'b0, line_cnt} < y_end;
  assign last_x = {1'b0, pix_cnt} + ONE == x_end;
  assign last_y = {1'b0, line_cnt} + ONE == y_end;
  assign pix = state == CAPTURE && yuv_de && yuv_hsync && in_x && in_y && !vs_rise;
  assign eof = pix && last_x && last_y;
  assign mem_valid = ~fifo_empty;
  assign mem_data = fifo_empty ? '0 : head;
  assign pop = mem_valid & mem_ready;
  assign busy = state != IDLE;
  yuv_word_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_en    (push_v),
    .wr_data  (push_w),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      line_de <= 1'b0;
      pix_cnt <= '0;
      line_cnt <= '0;
    end else begin
      vs_q <= yuv_vsync;
      hs_q <= yuv_hsync;
      if (!yuv_hsync) pix_cnt <= '0;
      else if (yuv_de && pix_cnt != CMAX) pix_cnt <= pix_cnt + CW'(1);
      if (hs_fall) line_de <= 1'b0;
      else if (yuv_de && yuv_hsync) line_de <= 1'b1;
      if (vs_rise) line_cnt <= '0;
      else if (hs_fall && line_de && line_cnt != CMAX) line_cnt <= line_cnt + CW'(1);
    end
  // A half pair left open when vsync cuts the frame short is flushed with a zero upper pixel
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      phase <= 1'b0;
      lo <= '0;
      push_v <= 1'b0;
      push_w <= '0;
    end else begin
      push_v <= 1'b0;
      if (state == CAPTURE && vs_rise && phase) begin
        push_v <= 1'b1;
        push_w <= pack_pair(PIX_PAD, lo);
        phase <= 1'b0;
      end else if (pix) begin
        if (phase || last_x) begin
          push_v <= 1'b1;
          push_w <= phase ? pack_pair(yuv_d, lo) : pack_pair(PIX_PAD, yuv_d);
          phase <= 1'b0;
        end else begin
          lo <= yuv_d;
          phase <= 1'b1;
        end
      end else if (!yuv_hsync) phase <= 1'b0;
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      stop_pend <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
      err_ovf <= 1'b0;
      err_short <= 1'b0;
      mem_addr <= '0;
      win_x0 <= '0;
      win_y0 <= '0;
      win_w <= '0;
      win_h <= '0;
      frames_q <= '0;
      base_q <= '0;
    end else begin
      frame_done <= 1'b0;
      if (cap_stop && state != IDLE) stop_pend <= 1'b1;
      if (push_v && fifo_full) err_ovf <= 1'b1;
      if (pop) mem_addr <= mem_addr + ADDR_W'(1);
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (cap_start && !cap_stop && cfg_w != '0 && cfg_h != '0) begin
            win_x0 <= cfg_x0;
            win_y0 <= cfg_y0;
            win_w <= cfg_w;
            win_h <= cfg_h;
            frames_q <= cfg_frames;
            base_q <= cfg_base;
            frame_cnt <= '0;
            err_ovf <= 1'b0;
            err_short <= 1'b0;
            state <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (cap_stop || stop_pend) state <= IDLE;
          else if (vs_rise) begin
            mem_addr <= base_q;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            err_short <= 1'b1;
            state <= FLUSH;
          end else if (eof) state <= FLUSH;
        end
        FLUSH: begin
          if (fifo_empty && !push_v) begin
            frame_done <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            state <= DONE;
          end
        end
        DONE: state <= (stop_pend || cap_stop || (frames_q != '0 && frame_cnt == frames_q)) ? IDLE : WAIT_VS;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_yuv422_capture_ctrl.sv
// tb_yuv422_capture_ctrl: directed scenario tests with hand-computed expected words
module tb_yuv422_capture_ctrl;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [15:0] yuv_d = '0;
  logic yuv_de = 1'b0, yuv_hsync = 1'b0, yuv_vsync = 1'b0;
  logic cap_start = 1'b0, cap_stop = 1'b0;
  logic [10:0] cfg_x0 = '0, cfg_y0 = '0, cfg_w = '0, cfg_h = '0;
  logic [7:0] cfg_frames = '0;
  logic [23:0] cfg_base = '0;
  logic mem_valid, mem_ready = 1'b1, busy, frame_done, err_ovf, err_short;
  logic [23:0] mem_addr;
  logic [31:0] mem_data;
  logic [7:0] frame_cnt;
  int checks = 0, failures = 0, ndone = 0;
  logic [23:0] qa[$];
  logic [31:0] qd[$];

  yuv422_capture_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .yuv_d(yuv_d), .yuv_de(yuv_de),
    .yuv_hsync(yuv_hsync), .yuv_vsync(yuv_vsync), .cap_start(cap_start), .cap_stop(cap_stop),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_frames(cfg_frames),
    .cfg_base(cfg_base), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_ovf(err_ovf), .err_short(err_short)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (mem_valid && mem_ready) begin
      qa.push_back(mem_addr);
      qd.push_back(mem_data);
    end
    if (frame_done) ndone++;
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic arm(input int x0, input int y0, input int w, input int h, input int fr, input logic [23:0] base);
    cfg_x0 = 11'(x0); cfg_y0 = 11'(y0); cfg_w = 11'(w); cfg_h = 11'(h);
    cfg_frames = 8'(fr); cfg_base = base;
    cap_start = 1'b1; tick; cap_start = 1'b0;
  endtask

  task automatic vs_pulse;
    yuv_vsync = 1'b1; repeat (2) tick; yuv_vsync = 1'b0; repeat (2) tick;
  endtask

  task automatic send_frame(input int nx, input int ny, input int stop_line);
    vs_pulse();
    for (int l = 0; l < ny; l++) begin
      yuv_hsync = 1'b1; tick;
      for (int p = 0; p < nx; p++) begin
        yuv_de = 1'b1; yuv_d = {8'(l), 8'(p)}; tick;
      end
      yuv_de = 1'b0; yuv_d = '0; tick;
      yuv_hsync = 1'b0;
      if (l == stop_line) begin
        cap_stop = 1'b1; tick; cap_stop = 1'b0;
      end
      repeat (3) tick;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks++;
    if ({mem_valid, busy, frame_done, err_ovf, err_short} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=00000", {mem_valid, busy, frame_done, err_ovf, err_short});
    end
    checks++;
    if (frame_cnt !== 8'd0 || mem_addr !== 24'd0 || mem_data !== 32'd0) begin
      failures++; $display("FAIL reset_values cnt=%0d addr=%h data=%h want all 0", frame_cnt, mem_addr, mem_data);
    end
    sys_rst_n = 1'b1; tick;
  endtask

  task automatic test_start_ignored;
    arm(0, 0, 0, 2, 1, 24'h0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_w_start busy=%b want=0", busy); end
    cap_stop = 1'b1; arm(0, 0, 2, 2, 1, 24'h0); cap_stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_stop_same_cycle busy=%b want=0", busy); end
  endtask

  task automatic test_window;
    int w0 = qa.size(), d0 = ndone;
    logic [31:0] exp[4] = '{32'h0103_0102, 32'h0105_0104, 32'h0203_0202, 32'h0205_0204};
    arm(2, 1, 4, 2, 1, 24'h000100);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL window_busy got=%b want=1", busy); end
    send_frame(8, 4, -1);
    wait_idle(200);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL window_idle busy=%b want=0", busy); end
    checks++;
    if (qa.size() - w0 != 4) begin failures++; $display("FAIL window_count got=%0d want=4", qa.size() - w0); end
    for (int k = 0; k < 4; k++)
      if (qa.size() > w0 + k) begin
        checks++;
        if (qa[w0+k] !== 24'h100 + 24'(k) || qd[w0+k] !== exp[k]) begin
          failures++; $display("FAIL window_word%0d addr=%h data=%h want addr=%h data=%h", k, qa[w0+k], qd[w0+k], 24'h100 + 24'(k), exp[k]);
        end
      end
    checks++;
    if (ndone - d0 != 1 || frame_cnt !== 8'd1) begin
      failures++; $display("FAIL window_done pulses=%0d cnt=%0d want 1,1", ndone - d0, frame_cnt);
    end
  endtask

  task automatic test_odd_width_wrap;
    int w0 = qa.size();
    arm(0, 0, 3, 1, 1, 24'hFFFFFF);
    send_frame(4, 2, -1);
    wait_idle(200);
    checks++;
    if (qa.size() - w0 != 2) begin failures++; $display("FAIL odd_count got=%0d want=2", qa.size() - w0); end
    if (qa.size() >= w0 + 2) begin
      checks++;
      if (qa[w0] !== 24'hFFFFFF || qd[w0] !== 32'h0001_0000) begin
        failures++; $display("FAIL odd_word0 addr=%h data=%h want FFFFFF 00010000", qa[w0], qd[w0]);
      end
      checks++;
      if (qa[w0+1] !== 24'h000000 || qd[w0+1] !== 32'h0000_0002) begin
        failures++; $display("FAIL odd_word1 addr=%h data=%h want 000000 00000002", qa[w0+1], qd[w0+1]);
      end
    end
  endtask

  task automatic test_overflow;
    int w0;
    mem_ready = 1'b0;
    arm(0, 0, 64, 1, 1, 24'h000400);
    send_frame(64, 1, -1);
    checks++;
    if (err_ovf !== 1'b1 || mem_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_flag err_ovf=%b valid=%b want 1,1", err_ovf, mem_valid);
    end
    w0 = qa.size();
    mem_ready = 1'b1;
    wait_idle(200);
    checks++;
    if (qa.size() - w0 != 16) begin failures++; $display("FAIL ovf_count got=%0d want=16", qa.size() - w0); end
    if (qa.size() >= w0 + 16) begin
      checks++;
      if (qd[w0] !== 32'h0001_0000 || qa[w0+15] !== 24'h00040F || qd[w0+15] !== 32'h001F_001E) begin
        failures++; $display("FAIL ovf_words first=%h last_addr=%h last=%h want 00010000 00040F 001F001E", qd[w0], qa[w0+15], qd[w0+15]);
      end
    end
  endtask

  task automatic test_continuous_stop;
    int w0 = qa.size(), d0 = ndone;
    arm(0, 0, 2, 2, 0, 24'h000300);
    send_frame(4, 3, -1);
    send_frame(4, 3, 0);
    wait_idle(200);
    checks++;
    if (busy !== 1'b0 || ndone - d0 != 2 || frame_cnt !== 8'd2) begin
      failures++; $display("FAIL stop_frames busy=%b pulses=%0d cnt=%0d want 0,2,2", busy, ndone - d0, frame_cnt);
    end
    send_frame(4, 3, -1);
    checks++;
    if (qa.size() - w0 != 4) begin failures++; $display("FAIL stop_count got=%0d want=4", qa.size() - w0); end
    if (qa.size() >= w0 + 4) begin
      checks++;
      if (qa[w0+2] !== 24'h300 || qd[w0+2] !== 32'h0001_0000 || qa[w0+3] !== 24'h301 || qd[w0+3] !== 32'h0101_0100) begin
        failures++; $display("FAIL stop_frame2 a2=%h d2=%h a3=%h d3=%h want 300 00010000 301 01010100", qa[w0+2], qd[w0+2], qa[w0+3], qd[w0+3]);
      end
    end
  endtask

  task automatic test_short_frame;
    int w0 = qa.size(), d0 = ndone;
    arm(0, 0, 2, 2, 1, 24'h000500);
    send_frame(4, 1, -1);
    vs_pulse();
    wait_idle(200);
    checks++;
    if (err_short !== 1'b1 || ndone - d0 != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL short_flags err_short=%b pulses=%0d busy=%b want 1,1,0", err_short, ndone - d0, busy);
    end
    checks++;
    if (qa.size() - w0 != 1) begin failures++; $display("FAIL short_count got=%0d want=1", qa.size() - w0); end
    else begin
      checks++;
      if (qa[w0] !== 24'h500 || qd[w0] !== 32'h0001_0000) begin
        failures++; $display("FAIL short_word addr=%h data=%h want 000500 00010000", qa[w0], qd[w0]);
      end
    end
  endtask

  task automatic test_reset_mid_capture;
    int w0 = qa.size(), d0 = ndone;
    mem_ready = 1'b0;
    arm(0, 0, 10, 2, 1, 24'h000600);
    send_frame(10, 1, -1);
    checks++;
    if (mem_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rstcap_pre valid=%b busy=%b want 1,1", mem_valid, busy);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) begin
      failures++; $display("FAIL rstcap_async valid=%b busy=%b cnt=%0d want 0,0,0", mem_valid, busy, frame_cnt);
    end
    repeat (2) tick;
    sys_rst_n = 1'b1;
    mem_ready = 1'b1;
    send_frame(10, 2, -1);
    checks++;
    if (qa.size() != w0 || ndone != d0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstcap_after writes=%0d pulses=%0d busy=%b want 0,0,0", qa.size() - w0, ndone - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_start_ignored();
    test_window();
    test_odd_width_wrap();
    test_overflow();
    test_continuous_stop();
    test_short_frame();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/yuv422_capture_ctrl.md
Name: yuv422_capture_ctrl

Overview:
Frame capture controller downstream of the RGB565-to-YUV422 converter. It arms on a software request and synchronises to the video frame boundary. It crops a programmable window from the YUV422 stream, packs pixel pairs into 32-bit words and buffers them in a small FIFO. It then drains the FIFO to a word-addressed memory write port with a valid/ready handshake, sequencing a programmed number of frames.

Parameters:
FIFO_AW, 4, log2 of packing FIFO depth (16 words)
ADDR_W, 24, memory word-address width
CW, 11, pixel/line counter and window-config width

Ports:
sys_clk  in  1  single clock; the YUV422 stream and the memory port are synchronous to it
sys_rst_n  in  1  asynchronous active-low reset
yuv_d  in  16  {C,Y} pixel from converter
yuv_de  in  1  pixel valid
yuv_hsync  in  1  high during active line
yuv_vsync  in  1  rising edge = new frame
cap_start  in  1  one-cycle pulse; latches cfg_*; ignored unless IDLE
cap_stop  in  1  one-cycle pulse; stop after current frame
cfg_x0, cfg_y0  in  CW  window origin (pixel, line)
cfg_w, cfg_h  in  CW  window size; 0 in either = no capture, start ignored
cfg_frames  in  8  frames to capture; 0 = continuous until stop
cfg_base  in  ADDR_W  frame base word address
mem_valid  out  1  write word valid
mem_addr  out  ADDR_W  word address
mem_data  out  32  packed word
mem_ready  in  1  sink accepts word when valid&ready
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse per completed frame
frame_cnt  out  8  frames completed since start
err_ovf  out  1  sticky; FIFO full when a word was pushed
err_short  out  1  sticky; vsync arrived before window complete

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; FIFO emptied; counters 0. Reset mid-frame discards buffered data; no done pulse.
- Counters: pix_cnt cleared while yuv_hsync=0, +1 per yuv_de. line_cnt cleared on vsync rising edge, +1 on hsync falling edge of a line that had ≥1 DE. Both saturate at 2^CW-1.
- In-window: pix_cnt in [x0, x0+w-1] and line_cnt in [y0, y0+h-1]; sums computed CW+1 bits wide to avoid wrap.
- Packing: first in-window pixel of a pair goes to [15:0], second to [31:16]. The word is pushed on the second pixel. Odd w: the last pixel of each line is pushed with [31:16]=0; the pair phase resets every line.
- FIFO: show-ahead; mem_valid = !empty; mem_data = head. Pop on valid&ready.
- Latency: pixel accepted at cycle n completes a word; the word is in the FIFO at n+1, and mem_valid is high at n+2 at earliest.
- Push when full: word dropped, err_ovf set; address does not advance for dropped words.
- mem_addr = cfg_base at frame start, +1 per accepted word; wraps modulo 2^ADDR_W.
- States:
  - IDLE: on cap_start with w,h≠0, latch cfg, clear frame_cnt/err_* -> WAIT_VS.
  - WAIT_VS: on vsync rising edge -> CAPTURE, reset address.
  - CAPTURE: on the last in-window pixel of line y0+h-1 (after its push) -> FLUSH. On vsync rising edge first: err_short=1, flush the partial word -> FLUSH.
  - FLUSH: on FIFO empty -> DONE.
  - DONE (1 cycle): frame_done=1, frame_cnt+1. Then -> IDLE if stop pending or frame_cnt+1==cfg_frames (cfg_frames≠0); else -> WAIT_VS.
- cap_stop in any non-IDLE state sets stop_pending. In WAIT_VS it goes directly to IDLE with no done pulse. Cleared on entry to IDLE.
- cap_start and cap_stop in the same IDLE cycle: stop wins, remain IDLE.
- cfg_* changes while busy have no effect.

Decomposition:
- Shared package: state enum (IDLE, WAIT_VS, CAPTURE, FLUSH, DONE), pixel-pair packing constants, default widths.
- One sub-module: yuv_word_fifo (sync FIFO, show-ahead, full/empty, parameter FIFO_AW, 32-bit).

Test Plan:
- x0=2,y0=1,w=4,h=2,frames=1, 8x4 frame of incrementing pixels, ready=1 -> 4 words at base..base+3; word0={px(1,3),px(1,2)}; one frame_done; busy falls after.
- w=3,h=1 -> 2 words per frame, second word [31:16]=0.
- ready held 0 for 40 cycles during a 64-pixel window -> FIFO fills at 16 words, err_ovf=1, exactly 16 words delivered after ready returns.
- frames=0, cap_stop mid-frame 2 -> frame 2 completes, frame_done count=2, IDLE; no frame 3 writes.
- vsync pulse after 1 of 2 window lines -> err_short=1, frame_done pulses, partial-line words flushed.
- Assert sys_rst_n low during CAPTURE with 5 words buffered -> mem_valid=0 immediately; no further writes; frame_cnt=0.
